systolic_input_feeder: RTL and testbench
========================================

Name: systolic_input_feeder

Overview:
Transmit side of the systolic array's left-edge interface.
- Accepts one SIZE x SIZE operand matrix, one row per handshake.
- Buffers the full matrix.
- Streams it into the array as diagonally skewed lane vectors: lane i is delayed i cycles, as the PE grid requires.
- Sits between the operand memory/DMA and the systolic_array input edge; one instance for activations, one for weights.

Parameters:
- WIDTH, 8, element bit width.
- SIZE, 10, matrix dimension; number of array lanes.
- STEP_W, $clog2(2*SIZE), width of the stream step counter (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_row holds a valid matrix row.
- in_ready  out  1  feeder accepts a row this cycle.
- in_row  in  SIZE*WIDTH  row r; element j is at bits [j*WIDTH +: WIDTH].
- out_valid  out  1  out_lane holds a valid skew step.
- out_ready  in  1  array side advances this cycle (low = stall).
- out_lane  out  SIZE*WIDTH  lane i is at bits [i*WIDTH +: WIDTH].
- out_lane_mask  out  SIZE  bit i = lane i carries a real element; otherwise lane i is driven 0.
- done  out  1  one-cycle pulse after the last step is consumed.

Behaviour:
- FSM states: LOAD, STREAM, DONE.
- Reset values: state LOAD, row_cnt 0, step 0, in_ready 1, out_valid 0, out_lane 0, out_lane_mask 0, done 0. The buffer contents are not reset.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, buf[row_cnt] <= in_row and row_cnt increments.
  - On acceptance of row SIZE-1, go to STREAM next cycle with step=0 and in_ready=0.
- STREAM:
  - out_valid=1; total 2*SIZE-1 steps (t = 0..2*SIZE-2).
  - At step t, lane i = buf[i][t-i] and mask[i]=1 when 0 <= t-i < SIZE; else lane i = 0 and mask[i]=0.
  - Outputs are registered: the values for step t are visible in the same cycle out_valid is high with step=t.
  - step advances only on out_valid&&out_ready.
  - While out_ready=0, out_lane, out_lane_mask and step hold stable.
  - When step 2*SIZE-2 is consumed, go to DONE.
- DONE: for one cycle, done=1, out_valid=0, out_lane=0, mask=0; then go to LOAD with row_cnt=0.
- Minimum latency: from the cycle after the last row is accepted to the first out_valid is 1 cycle. A full transfer is SIZE load cycles + (2*SIZE-1) stream cycles + 1 done cycle, with no stalls.
- in_valid during STREAM/DONE is ignored (in_ready=0); no row is lost or duplicated.
- out_ready is ignored outside STREAM.
- Reset asserted mid-LOAD or mid-STREAM: the next cycle shows reset values. A partially loaded matrix is discarded (row_cnt 0), and done is not pulsed.
- No arithmetic: elements pass through unmodified, with bit-exact WIDTH. Sign interpretation is the array's concern.

Optional Feature:
SYSTOLIC_FEEDER_TRANSPOSE_EN
- Defined: lane i at step t = buf[t-i][i], i.e. column-major streaming, for feeding weights without a separate transpose pass. Mask rule and timing are unchanged.
- Undefined: row-major streaming as above; no transpose logic is synthesised.

Decomposition:
- Shared package systolic_pkg holds:
  - default WIDTH/SIZE localparams;
  - the feeder_state_t enum {LOAD, STREAM, DONE};
  - a function giving the step count (2*SIZE-1), shared with the array and result collector.
- Natural sub-module: systolic_skew_mux. It is combinational: (buf, step) -> (out_lane, out_lane_mask). Both the row-major and transpose variants live there.
- The feeder top owns the FSM, counters and buffer registers.

Test Plan:
All scenarios use SIZE=10, WIDTH=8 and buf[r][c]=10*r+c.
- Back-to-back load, out_ready=1 -> in_ready drops after 10 accepted rows. Then, as step outputs:
  - t=0: lane0=0, mask=10'b0000000001.
  - t=5: lane2=23, lane5=50, mask=10'b0000111111.
  - t=18: lane9=99, mask=10'b1000000000.
  - done pulses exactly one cycle after t=18 is consumed.
  - Then in_ready=1.
- out_ready toggling 1,0,0,1 during STREAM -> out_lane/mask/step are frozen during the low cycles. Exactly 19 handshakes occur; done fires once.
- in_valid held 1 during STREAM with a different row -> in_ready=0 throughout. The stream data matches the original matrix. The next LOAD starts at row 0.
- Reset pulsed at t=7 of STREAM -> the next cycle shows out_valid=0, done=0, in_ready=1. A fresh load then streams correctly from t=0.
- Reset after 4 rows accepted -> a full 10-row reload is required before STREAM. There is no out_valid until the tenth new row is accepted.
- With SYSTOLIC_FEEDER_TRANSPOSE_EN defined:
  - t=5: lane2=32, lane5=05.
  - t=18: lane9=99.
  - The mask is identical to the row-major case.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, feeder state type and step-count helper for the systolic datapath.
// No ports. Used by the feeder, the array and the result collector.
package systolic_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_SIZE  = 10;
   typedef enum logic [1:0] {LOAD, STREAM, DONE} feeder_state_t;
   // Number of skewed steps needed to push a SIZE x SIZE matrix through the array edge.
   function automatic int stream_steps(input int size);
      return 2 * size - 1;
   endfunction
endpackage

// File: rtl/systolic_skew_mux.sv
// systolic_skew_mux: combinational selection of one diagonally skewed lane vector from a buffered matrix.
// Ports: mat_i  - buffered matrix, row r at mat_i[r], element c at [c*WIDTH +: WIDTH]
//        step_i - skew step t
//        lane_o - lane i at [i*WIDTH +: WIDTH], zero where the lane carries no element
//        mask_o - bit i set when lane i carries a real element (0 <= t-i < SIZE)
// Macro SYSTOLIC_FEEDER_TRANSPOSE_EN: when defined, lanes stream columns instead of rows.
module systolic_skew_mux
   import systolic_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SIZE   = DEF_SIZE,
   parameter int STEP_W = $clog2(2 * SIZE)
) (
   input  logic [SIZE-1:0][SIZE*WIDTH-1:0] mat_i,
   input  logic [STEP_W-1:0]               step_i,
   output logic [SIZE*WIDTH-1:0]           lane_o,
   output logic [SIZE-1:0]                 mask_o
);
   always_comb begin
      lane_o = '0;
      mask_o = '0;
      for (int i = 0; i < SIZE; i++) begin
         // k is how far lane i has progressed into its row (or column)
         automatic int k = int'(step_i) - i;
         if (k >= 0 && k < SIZE) begin
            mask_o[i] = 1'b1;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
            lane_o[i*WIDTH +: WIDTH] = mat_i[k][i*WIDTH +: WIDTH];
`else
            lane_o[i*WIDTH +: WIDTH] = mat_i[i][k*WIDTH +: WIDTH];
`endif
         end
      end
   end
endmodule

// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: buffers one SIZE x SIZE matrix row by row and streams it as skewed lane vectors.
// Ports: clk, reset        - clock, synchronous active-high reset
//        in_valid/in_ready - row handshake, in_row element j at [j*WIDTH +: WIDTH]
//        out_valid/out_ready - step handshake, out_ready low stalls the stream
//        out_lane, out_lane_mask - registered lane vector and per-lane valid mask
//        done              - one-cycle pulse after the last step is consumed
// Macro SYSTOLIC_FEEDER_TRANSPOSE_EN (in systolic_skew_mux): column-major streaming.
module systolic_input_feeder
   import systolic_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SIZE   = DEF_SIZE,
   parameter int STEP_W = $clog2(2 * SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SIZE*WIDTH-1:0] in_row,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SIZE*WIDTH-1:0] out_lane,
   output logic [SIZE-1:0]       out_lane_mask,
   output logic                  done
);
   localparam int ROW_W = SIZE > 1 ? $clog2(SIZE) : 1;
   localparam int STEPS = stream_steps(SIZE);
   feeder_state_t                  state_q, state_d;
   logic [ROW_W-1:0]               row_cnt_q, row_cnt_d;
   logic [STEP_W-1:0]              step_q, step_d;
   logic [SIZE-1:0][SIZE*WIDTH-1:0] mat_q, mat_d;
   logic [SIZE*WIDTH-1:0]          lane_q, lane_d, mux_lane;
   logic [SIZE-1:0]                mask_q, mask_d, mux_mask;
   logic                           accept, fire, last_row, last_step;
   assign accept    = in_valid && state_q == LOAD;
   assign fire      = out_ready && state_q == STREAM;
   assign last_row  = row_cnt_q == ROW_W'(SIZE - 1);
   assign last_step = step_q == STEP_W'(STEPS - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD;
         row_cnt_q <= '0;
         step_q    <= '0;
         lane_q    <= '0;
         mask_q    <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         step_q    <= step_d;
         lane_q    <= lane_d;
         mask_q    <= mask_d;
      end
   end
   always_ff @(posedge clk) begin
      mat_q <= mat_d;
   end
   always_comb begin
      case (state_q)
         LOAD:    state_d = accept && last_row ? STREAM : LOAD;
         STREAM:  state_d = fire && last_step ? DONE : STREAM;
         default: state_d = LOAD;
      endcase
      row_cnt_d = accept ? (last_row ? '0 : row_cnt_q + 1'b1) : row_cnt_q;
      step_d    = state_q == STREAM && !(fire && last_step) ? step_q + STEP_W'(fire) : '0;
      for (int r = 0; r < SIZE; r++) begin
         mat_d[r] = accept && row_cnt_q == ROW_W'(r) ? in_row : mat_q[r];
      end
   end
   // The mux looks at next-cycle buffer and step so the lane register already holds step t when step_q is t.
   systolic_skew_mux #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .STEP_W(STEP_W)
   ) u_mux (
      .mat_i (mat_d),
      .step_i(step_d),
      .lane_o(mux_lane),
      .mask_o(mux_mask)
   );
   always_comb begin
      lane_d = state_d == STREAM ? mux_lane : '0;
      mask_d = state_d == STREAM ? mux_mask : '0;
   end
   assign in_ready      = state_q == LOAD;
   assign out_valid     = state_q == STREAM;
   assign done          = state_q == DONE;
   assign out_lane      = lane_q;
   assign out_lane_mask = mask_q;
endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb_systolic_input_feeder: randomized self-checking bench for systolic_input_feeder against a matrix-level model.
module tb_systolic_input_feeder;
   localparam int W = 8;
   localparam int N = 10;
   localparam int S = 2 * N - 1;
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
   localparam bit TR = 1'b1;
`else
   localparam bit TR = 1'b0;
`endif
   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [N*W-1:0] in_row = '0;
   logic           in_ready, out_valid, done;
   logic [N*W-1:0] out_lane;
   logic [N-1:0]   out_lane_mask;
   int             errors = 0;
   int             checks = 0;
   int             m[N][N];

   systolic_input_feeder #(.WIDTH(W), .SIZE(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_row       (in_row),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_lane     (out_lane),
      .out_lane_mask(out_lane_mask),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void fill(input bit fixed);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = fixed ? 10 * r + c : int'($urandom_range(255));
   endfunction

   function automatic logic [N*W-1:0] row_of(input int r);
      logic [N*W-1:0] v = '0;
      for (int c = 0; c < N; c++) v[c*W +: W] = W'(m[r][c]);
      return v;
   endfunction

   // Lane i at step t carries element t-i of row i (column i when transposed), if that index exists.
   function automatic logic [N*W-1:0] exp_lane(input int t);
      logic [N*W-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*W +: W] = W'(TR ? m[t-i][i] : m[i][t-i]);
      return v;
   endfunction

   function automatic logic [N-1:0] exp_mask(input int t);
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = t - i >= 0 && t - i < N;
      return v;
   endfunction

   task automatic load_rows(input int n);
      for (int r = 0; r < n; r++) begin
         in_valid = 1'b1;
         in_row = row_of(r);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_row = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, done, out_lane_mask, out_lane} !== {3'b100, {N{1'b0}}, {N*W{1'b0}}})
         $display("FAIL reset_values: got rdy/val/done=%b%b%b mask=%h lane=%h, want 100 mask=0 lane=0",
                  in_ready, out_valid, done, out_lane_mask, out_lane);
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, done} !== 3'b100)
         $display("FAIL idle_after_reset: got rdy/val/done=%b%b%b want 100", in_ready, out_valid, done);
      if ({in_ready, out_valid, done} !== 3'b100) errors++;
      if ({in_ready, out_valid, done, out_lane_mask, out_lane} !== {3'b100, {N{1'b0}}, {N*W{1'b0}}} && checks == 1) errors++;
      out_ready = 1'b0;
   endtask

   // mode 0: out_ready always 1, mode 1: repeating 1,0,0,1, mode 2: random stalls
   task automatic test_stream(input string name, input bit fixed, input int mode, input bit hold_in, input bit gaps);
      int t = 0;
      int n = 0;
      bit rdy;
      logic [N*W-1:0] exp;
      fill(fixed);
      for (int r = 0; r < N; r++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(2)) @(negedge clk);
         end
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s load_row%0d: got in_ready=%b out_valid=%b want 1 0", name, r, in_ready, out_valid);
         end
         in_valid = 1'b1;
         in_row = row_of(r);
         @(negedge clk);
      end
      in_valid = hold_in;
      in_row = hold_in ? {N*W{1'b1}} ^ row_of(0) : '0;
      while (t < S && n < 400) begin
         exp = exp_lane(t);
         checks++;
         if ({out_valid, in_ready, done, out_lane_mask, out_lane} !== {3'b100, exp_mask(t), exp}) begin
            errors++;
            $display("FAIL %s step%0d: got val/rdy/done=%b%b%b mask=%b lane=%h, want 100 mask=%b lane=%h",
                     name, t, out_valid, in_ready, done, out_lane_mask, out_lane, exp_mask(t), exp);
         end
         if (fixed && (t == 0 || t == 5 || t == 18)) begin
            checks++;
            if ((t == 0 && (out_lane_mask !== 10'b0000000001 || out_lane[0 +: W] !== 8'd0)) ||
                (t == 5 && (out_lane_mask !== 10'b0000111111 || out_lane[2*W +: W] !== (TR ? 8'd32 : 8'd23) ||
                            out_lane[5*W +: W] !== (TR ? 8'd5 : 8'd50))) ||
                (t == 18 && (out_lane_mask !== 10'b1000000000 || out_lane[9*W +: W] !== 8'd99))) begin
               errors++;
               $display("FAIL %s known_step%0d: got mask=%b lane=%h", name, t, out_lane_mask, out_lane);
            end
         end
         rdy = mode == 0 ? 1'b1 : mode == 1 ? (n % 4 == 0 || n % 4 == 3) : ($urandom_range(3) != 0);
         out_ready = rdy;
         if (hold_in) in_row = {$urandom, $urandom, $urandom};
         @(negedge clk);
         if (rdy) t++;
         n++;
      end
      checks++;
      if (t < S) begin
         errors++;
         $display("FAIL %s stream_timeout: got %0d steps want %0d", name, t, S);
      end
      out_ready = 1'($urandom_range(1));
      checks++;
      if ({out_valid, in_ready, done, out_lane_mask, out_lane} !== {3'b001, {N{1'b0}}, {N*W{1'b0}}}) begin
         errors++;
         $display("FAIL %s done_cycle: got val/rdy/done=%b%b%b mask=%b lane=%h want 001 0 0",
                  name, out_valid, in_ready, done, out_lane_mask, out_lane);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, done} !== 3'b010) begin
         errors++;
         $display("FAIL %s back_to_load: got val/rdy/done=%b%b%b want 010", name, out_valid, in_ready, done);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_stream();
      fill(1'b0);
      load_rows(N);
      out_ready = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_lane !== exp_lane(7)) begin
         errors++;
         $display("FAIL rst_stream_t7: got val=%b lane=%h want 1 lane=%h", out_valid, out_lane, exp_lane(7));
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, done, in_ready, out_lane_mask, out_lane} !== {3'b001, {N{1'b0}}, {N*W{1'b0}}}) begin
         errors++;
         $display("FAIL rst_stream_values: got val/done/rdy=%b%b%b mask=%b lane=%h want 001 0 0",
                  out_valid, done, in_ready, out_lane_mask, out_lane);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, done, in_ready} !== 3'b001) begin
         errors++;
         $display("FAIL rst_stream_no_done: got val/done/rdy=%b%b%b want 001", out_valid, done, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      fill(1'b0);
      load_rows(4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({in_ready, out_valid, done} !== 3'b100) begin
         errors++;
         $display("FAIL rst_load_values: got rdy/val/done=%b%b%b want 100", in_ready, out_valid, done);
      end
      fill(1'b0);
      for (int r = 0; r < N; r++) begin
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_load_row%0d: got val=%b rdy=%b want 0 1", r, out_valid, in_ready);
         end
         in_valid = 1'b1;
         in_row = row_of(r);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_lane !== exp_lane(0) || out_lane_mask !== exp_mask(0)) begin
         errors++;
         $display("FAIL rst_load_first_step: got val=%b mask=%b lane=%h want 1 mask=%b lane=%h",
                  out_valid, out_lane_mask, out_lane, exp_mask(0), exp_lane(0));
      end
      out_ready = 1'b1;
      repeat (S) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL rst_load_done: got done=%b want 1", done);
      end
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_stream("back_to_back", 1'b1, 0, 1'b0, 1'b0);
      test_stream("stall_1001", 1'b1, 1, 1'b0, 1'b0);
      test_stream("hold_in_valid", 1'b1, 0, 1'b1, 1'b0);
      test_stream("reload_after_hold", 1'b0, 0, 1'b0, 1'b0);
      test_reset_mid_stream();
      test_stream("after_rst_stream", 1'b0, 2, 1'b0, 1'b1);
      test_reset_mid_load();
      for (int k = 0; k < 4; k++) test_stream("random", 1'b0, 2, 1'($urandom_range(1)), 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
